// File: rtl/udp_transmit_framer.sv
// udp_transmit_framer
// Drains a byte FIFO of host transmit requests. It hunts for SYNC_BYTE, then
// re-emits a 16-byte header followed by UDP-size payload bytes as a 9-bit
// framed stream. Bit 8 marks header byte 0. Bytes are paced at one per four
// cycles or slower, so the handler's registered data_ready is never outrun.
// Optional feature: define UDP_TRANSMIT_FRAMER_TIMEOUT_EN to abort a packet
// when the FIFO starves mid-packet for TIMEOUT_LIMIT cycles.
//
//   state        | meaning
//   S_HUNT       | between packets, pop a byte whenever one is available
//   S_HUNT_CHECK | popped byte is visible, compare it against SYNC_BYTE
//   S_FETCH      | in a packet, pop the next byte (waits while the FIFO is empty)
//   S_CAPTURE    | latch the popped byte and validate the size field at index 15
//   S_SEND       | present the byte and strobe it once data_ready is high
//   S_GAP        | mandatory idle cycle, then fetch more or finish the packet
module udp_transmit_framer #(
    parameter logic [7:0]  SYNC_BYTE     = 8'hA5,
    parameter logic [15:0] MAX_PAYLOAD   = 16'd1472,
    parameter logic [15:0] TIMEOUT_LIMIT = 16'h00FF
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic [7:0] fifo_data_i,
    input  logic       fifo_empty_i,
    output logic       fifo_read_enable_o,
    output logic [8:0] data_o,
    output logic       data_enable_o,
    input  logic       data_ready_i,
    output logic       busy_o,
    output logic       packet_done_o,
    output logic       error_o
);

    typedef enum logic [2:0] {
        S_HUNT       = 3'd0,
        S_HUNT_CHECK = 3'd1,
        S_FETCH      = 3'd2,
        S_CAPTURE    = 3'd3,
        S_SEND       = 3'd4,
        S_GAP        = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  hold_q, hold_d;
    logic [7:0]  msb_q, msb_d;

    logic [15:0] size_w;
    logic        size_bad_w;
    logic        reject_w;
    logic        timeout_w;

    assign size_w     = {msb_q, fifo_data_i};
    assign size_bad_w = (size_w == 16'd0) || (size_w > MAX_PAYLOAD);
    assign reject_w   = (state_q == S_CAPTURE) && (idx_q == 5'd15) && size_bad_w;

`ifdef UDP_TRANSMIT_FRAMER_TIMEOUT_EN
    // Down-counter reloaded on every pop; expires on the TIMEOUT_LIMIT-th starved cycle.
    logic [15:0] starve_q, starve_d;

    // Starvation counter next value.
    always_comb begin
        starve_d = starve_q;
        if (fifo_read_enable_o) begin
            starve_d = TIMEOUT_LIMIT - 16'd1;
        end else if ((state_q == S_FETCH) && fifo_empty_i && (starve_q != 16'd0)) begin
            starve_d = starve_q - 16'd1;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            starve_q <= TIMEOUT_LIMIT - 16'd1;
        end else begin
            starve_q <= starve_d;
        end
    end

    assign timeout_w = (state_q == S_FETCH) && fifo_empty_i && (starve_q == 16'd0);
`else
    assign timeout_w = 1'b0;
`endif

    // State and datapath registers.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_HUNT;
            idx_q   <= 5'd0;
            cnt_q   <= 16'd0;
            hold_q  <= 8'd0;
            msb_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            msb_q   <= msb_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        msb_d   = msb_q;
        case (state_q)
            S_HUNT: begin
                if (!fifo_empty_i) state_d = S_HUNT_CHECK;
            end
            S_HUNT_CHECK: begin
                if (fifo_data_i == SYNC_BYTE) begin
                    idx_d   = 5'd0;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_HUNT;
                end
            end
            S_FETCH: begin
                if (timeout_w) begin
                    state_d = S_HUNT;
                end else if (!fifo_empty_i) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                hold_d = fifo_data_i;
                if (idx_q == 5'd14) msb_d = fifo_data_i;
                if (reject_w) begin
                    state_d = S_HUNT;
                end else begin
                    if (idx_q == 5'd15) cnt_d = size_w;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (data_ready_i) begin
                    // Index saturates at 16; from then on the counter tracks payload.
                    if (idx_q < 5'd16) begin
                        idx_d = idx_q + 5'd1;
                    end else begin
                        cnt_d = cnt_q - 16'd1;
                    end
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if ((idx_q < 5'd16) || (cnt_q != 16'd0)) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_HUNT;
                end
            end
            default: state_d = S_HUNT;
        endcase
    end

    // Outputs decoded from the current state; the pop strobe is held off during reset.
    always_comb begin
        fifo_read_enable_o = 1'b0;
        data_o             = 9'd0;
        data_enable_o      = 1'b0;
        packet_done_o      = 1'b0;
        error_o            = 1'b0;
        busy_o             = 1'b0;
        if (!reset_i && !fifo_empty_i &&
            ((state_q == S_HUNT) || ((state_q == S_FETCH) && !timeout_w))) begin
            fifo_read_enable_o = 1'b1;
        end
        if (state_q == S_SEND) begin
            data_o        = {(idx_q == 5'd0), hold_q};
            data_enable_o = data_ready_i;
        end
        packet_done_o = (state_q == S_GAP) && (idx_q == 5'd16) && (cnt_q == 16'd0);
        error_o       = reject_w || timeout_w;
        busy_o        = (state_q != S_HUNT) && (state_q != S_HUNT_CHECK) &&
                        !packet_done_o && !error_o;
    end

endmodule
